// File: rtl/alu_ctrl_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcodes, controller states
// and the arithmetic-opcode helper.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ADD    = 3'b000,
        SUB    = 3'b001,
        AND    = 3'b010,
        OR     = 3'b011,
        XOR    = 3'b100,
        NOT_A  = 3'b101,
        PASS_A = 3'b110,
        RSVD   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } ctrl_state_e;

    function automatic logic is_arith(input alu_op_e op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational C/Z/O/S flag derivation from the assembled result word and
// the carries observed around the MSB of a bit-serial run.
module alu_flag_gen
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             cin_msb,
    input  alu_op_e          opsel,
    input  logic             mode,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);

    // Carry and overflow only carry meaning for ADD/SUB; logic ops report 0.
    always_comb begin
        z_flag = (result == {WIDTH{1'b0}});
        s_flag = result[WIDTH-1];
        if (is_arith(opsel)) begin
            c_flag = carry;
            o_flag = mode ? (cin_msb ^ carry) : 1'b0;
        end else begin
            c_flag = 1'b0;
            o_flag = 1'b0;
        end
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: drives an external 1-bit ALU slice LSB-first, chains
// the carry through a register and returns the result word with flags.
module alu_serial_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_opsel,
    input  logic             req_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag,
    output logic             slice_op1,
    output logic             slice_op2,
    output logic             slice_cin,
    output logic [2:0]       slice_opsel,
    output logic             slice_mode,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_RUN   = RUN;
    localparam logic [1:0]       ST_DONE  = DONE;
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    alu_op_e          opsel_r;
    logic             mode_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CNT_W-1:0] idx_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             c_flag_r;
    logic             z_flag_r;
    logic             o_flag_r;
    logic             s_flag_r;
    logic             slice_op1_r;
    logic             slice_op2_r;
    logic [2:0]       slice_opsel_r;
    logic             slice_mode_r;

    logic             accept_s;
    logic             last_s;
    logic             rsvd_s;
    logic             bit_s;
    logic             cout_s;
    logic [CNT_W-1:0] idx_nxt_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             c_s;
    logic             z_s;
    logic             o_s;
    logic             s_s;
    logic             op1_nxt_s;
    logic             op2_nxt_s;
    logic [2:0]       opsel_nxt_s;
    logic             mode_nxt_s;

    assign accept_s  = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign last_s    = (idx_r == IDX_LAST);
    assign rsvd_s    = (opsel_r == RSVD);
    assign idx_nxt_s = idx_r + CNT_W'(1);

    // Reserved opcode ignores whatever the slice returns so the result is 0.
    always_comb begin
        if (rsvd_s) begin
            bit_s  = 1'b0;
            cout_s = 1'b0;
        end else begin
            bit_s  = slice_result;
            cout_s = slice_cout;
        end
        res_nxt_s        = res_r;
        res_nxt_s[idx_r] = bit_s;
    end

    // The flags see the full word including the MSB being captured this cycle.
    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result  (res_nxt_s),
        .carry   (cout_s),
        .cin_msb (carry_r),
        .opsel   (opsel_r),
        .mode    (mode_r),
        .c_flag  (c_s),
        .z_flag  (z_s),
        .o_flag  (o_s),
        .s_flag  (s_s)
    );

    // Slice inputs are registered one bit ahead so they line up with idx_r.
    always_comb begin
        op1_nxt_s   = 1'b0;
        op2_nxt_s   = 1'b0;
        opsel_nxt_s = 3'b000;
        mode_nxt_s  = 1'b0;
        if (accept_s) begin
            if (req_opsel != RSVD) begin
                op1_nxt_s   = req_a[0];
                op2_nxt_s   = req_b[0];
                opsel_nxt_s = req_opsel;
                mode_nxt_s  = req_mode;
            end else begin
                opsel_nxt_s = PASS_A;
            end
        end else if ((state_r == ST_RUN) && !last_s) begin
            if (!rsvd_s) begin
                op1_nxt_s   = a_r[idx_nxt_s];
                op2_nxt_s   = b_r[idx_nxt_s];
                opsel_nxt_s = opsel_r;
                mode_nxt_s  = mode_r;
            end else begin
                opsel_nxt_s = PASS_A;
            end
        end else begin
            opsel_nxt_s = 3'b000;
        end
    end

    // Slice-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_op1_r   <= 1'b0;
            slice_op2_r   <= 1'b0;
            slice_opsel_r <= 3'b000;
            slice_mode_r  <= 1'b0;
        end else begin
            slice_op1_r   <= op1_nxt_s;
            slice_op2_r   <= op2_nxt_s;
            slice_opsel_r <= opsel_nxt_s;
            slice_mode_r  <= mode_nxt_s;
        end
    end

    // Controller FSM, operand/result datapath and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            opsel_r      <= ADD;
            mode_r       <= 1'b0;
            res_r        <= {WIDTH{1'b0}};
            carry_r      <= 1'b0;
            idx_r        <= {CNT_W{1'b0}};
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {WIDTH{1'b0}};
            c_flag_r     <= 1'b0;
            z_flag_r     <= 1'b0;
            o_flag_r     <= 1'b0;
            s_flag_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r         <= req_a;
                        b_r         <= req_b;
                        opsel_r     <= alu_op_e'(req_opsel);
                        mode_r      <= req_mode;
                        res_r       <= {WIDTH{1'b0}};
                        carry_r     <= (req_opsel == SUB);
                        idx_r       <= {CNT_W{1'b0}};
                        req_ready_r <= 1'b0;
                        state_r     <= ST_RUN;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    res_r <= res_nxt_s;
                    if (last_s) begin
                        // Carry is cleared so slice_cin reads 0 while parked in DONE.
                        carry_r      <= 1'b0;
                        idx_r        <= {CNT_W{1'b0}};
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= res_nxt_s;
                        c_flag_r     <= c_s;
                        z_flag_r     <= z_s;
                        o_flag_r     <= o_s;
                        s_flag_r     <= s_s;
                        state_r      <= ST_DONE;
                    end else begin
                        carry_r <= cout_s;
                        idx_r   <= idx_nxt_s;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign c_flag      = c_flag_r;
    assign z_flag      = z_flag_r;
    assign o_flag      = o_flag_r;
    assign s_flag      = s_flag_r;
    assign slice_op1   = slice_op1_r;
    assign slice_op2   = slice_op2_r;
    assign slice_cin   = carry_r;
    assign slice_opsel = slice_opsel_r;
    assign slice_mode  = slice_mode_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: an 8-bit instance driven from a vector table with
// a response scoreboard, plus a 128-bit instance for latency and spacing.
module tb_alu_serial_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int WB = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference 1-bit slice: returns {cout, result}.
    function automatic logic [1:0] slice_model(input logic [2:0] op, input logic a, input logic b, input logic ci);
        logic bn;
        bn = ~b;
        case (op)
            3'b000:  return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
            3'b001:  return {(a & bn) | (a & ci) | (bn & ci), a ^ bn ^ ci};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            3'b101:  return {1'b0, ~a};
            3'b110:  return {1'b0, a};
            default: return 2'b00;
        endcase
    endfunction

    // 8-bit instance
    logic         req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [W-1:0] req_a, req_b, rsp_result;
    logic [2:0]   req_opsel, s_opsel;
    logic         c_f, z_f, o_f, s_f, s_op1, s_op2, s_cin, s_mode, s_res, s_cout;
    assign {s_cout, s_res} = slice_model(s_opsel, s_op1, s_op2, s_cin);

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_opsel(req_opsel), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .c_flag(c_f), .z_flag(z_f), .o_flag(o_f), .s_flag(s_f),
        .slice_op1(s_op1), .slice_op2(s_op2), .slice_cin(s_cin),
        .slice_opsel(s_opsel), .slice_mode(s_mode),
        .slice_result(s_res), .slice_cout(s_cout)
    );

    // 128-bit instance
    logic          b_req_valid, b_req_ready, b_req_mode, b_rsp_valid, b_rsp_ready;
    logic [WB-1:0] b_req_a, b_req_b, b_rsp_result;
    logic [2:0]    b_req_opsel, b_s_opsel;
    logic          b_c, b_z, b_o, b_s, b_op1, b_op2, b_cin, b_mode, b_sres, b_scout;
    assign {b_scout, b_sres} = slice_model(b_s_opsel, b_op1, b_op2, b_cin);

    alu_serial_ctrl #(.WIDTH(WB)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_a(b_req_a), .req_b(b_req_b),
        .req_opsel(b_req_opsel), .req_mode(b_req_mode),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
        .c_flag(b_c), .z_flag(b_z), .o_flag(b_o), .s_flag(b_s),
        .slice_op1(b_op1), .slice_op2(b_op2), .slice_cin(b_cin),
        .slice_opsel(b_s_opsel), .slice_mode(b_mode),
        .slice_result(b_sres), .slice_cout(b_scout)
    );

    int             b_acc_t[$];
    int             b_rsp_t[$];
    logic [WB+3:0]  b_rsp_v[$];
    always @(posedge clk) begin
        if (rst_n && b_req_valid && b_req_ready) b_acc_t.push_back(cyc);
        if (rst_n && b_rsp_valid && b_rsp_ready) begin
            b_rsp_t.push_back(cyc);
            b_rsp_v.push_back({b_c, b_z, b_o, b_s, b_rsp_result});
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         mode;
        int           hold;
        logic [W-1:0] res;
        logic [3:0]   flg;   // {c, z, o, s}
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [WB+3:0] act, input logic [WB+3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] all_outs();
        return {req_ready, rsp_valid, rsp_result, c_f, z_f, o_f, s_f, s_op1, s_op2, s_cin, s_opsel, s_mode};
    endfunction

    // Issue one request from a negedge, score the response, then handshake.
    task automatic run_vec(input vec_t v);
        int   n;
        vec_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        if (!req_ready) return;
        req_a = v.a; req_b = v.b; req_opsel = v.op; req_mode = v.mode; req_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < W + 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check("latency", n, W);
        check("result", rsp_result, e.res);
        check("flags", {c_f, z_f, o_f, s_f}, e.flg);
        check("slice_idle_done", {s_op1, s_op2, s_cin, s_opsel, s_mode}, 7'd0);
        for (int h = 0; h < v.hold; h++) begin
            req_a = ~v.a; req_b = ~v.b; req_opsel = 3'b000; req_valid = 1'b1;
            @(negedge clk);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_stable", {rsp_valid, c_f, z_f, o_f, s_f, rsp_result}, {1'b1, e.flg, e.res});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        vecs[0]  = '{8'hFF, 8'h01, 3'b000, 1'b1, 0, 8'h00, 4'b1100};
        vecs[1]  = '{8'h80, 8'h01, 3'b001, 1'b1, 5, 8'h7F, 4'b1010};
        vecs[2]  = '{8'h80, 8'h01, 3'b001, 1'b0, 0, 8'h7F, 4'b1000};
        vecs[3]  = '{8'hF0, 8'h3C, 3'b010, 1'b0, 0, 8'h30, 4'b0000};
        vecs[4]  = '{8'hAA, 8'h55, 3'b111, 1'b1, 0, 8'h00, 4'b0100};
        vecs[5]  = '{8'h0F, 8'h30, 3'b011, 1'b0, 0, 8'h3F, 4'b0000};
        vecs[6]  = '{8'hA5, 8'hFF, 3'b100, 1'b0, 0, 8'h5A, 4'b0000};
        vecs[7]  = '{8'h0F, 8'h00, 3'b101, 1'b0, 0, 8'hF0, 4'b0001};
        vecs[8]  = '{8'h81, 8'h7E, 3'b110, 1'b1, 0, 8'h81, 4'b0001};
        vecs[9]  = '{8'h01, 8'h02, 3'b001, 1'b0, 0, 8'hFF, 4'b0001};
        vecs[10] = '{8'h7F, 8'h01, 3'b000, 1'b1, 0, 8'h80, 4'b0011};
        vecs[11] = '{8'h05, 8'h05, 3'b001, 1'b1, 0, 8'h00, 4'b1100};
        vecs[12] = '{8'h7F, 8'h01, 3'b000, 1'b0, 0, 8'h80, 4'b0001};
        vecs[13] = '{8'h7F, 8'hFF, 3'b001, 1'b1, 0, 8'h80, 4'b0011};

        rst_n = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_opsel = 3'b000; req_mode = 1'b0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_a = '0; b_req_b = '0; b_req_opsel = 3'b000; b_req_mode = 1'b0; b_rsp_ready = 1'b0;
        #12;
        check("reset_outputs", all_outs(), 21'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", req_ready, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset while the run sits at idx 3.
        req_a = 8'hFF; req_b = 8'hFF; req_opsel = 3'b000; req_mode = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_run_slice", {s_op1, s_op2, s_opsel}, {1'b1, 1'b1, 3'b000});
        #2 rst_n = 1'b0;
        #1 check("mid_run_reset", all_outs(), 21'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_mid_reset", req_ready, 1'b1);
        run_vec('{8'h05, 8'h03, 3'b000, 1'b0, 0, 8'h08, 4'b0000});

        // Wide instance: two back-to-back ADDs with response always accepted.
        b_req_a = '1; b_req_b = 128'd1; b_req_opsel = 3'b000; b_req_mode = 1'b0;
        b_rsp_ready = 1'b1; b_req_valid = 1'b1;
        for (int k = 0; k < 400 && b_acc_t.size() < 1; k++) @(negedge clk);
        b_req_b = 128'd2;
        for (int k = 0; k < 400 && b_acc_t.size() < 2; k++) @(negedge clk);
        b_req_valid = 1'b0;
        for (int k = 0; k < 400 && b_rsp_t.size() < 2; k++) @(negedge clk);
        check("wide_accepts", b_acc_t.size(), 2);
        check("wide_responses", b_rsp_t.size(), 2);
        if (b_acc_t.size() == 2 && b_rsp_t.size() == 2) begin
            check("wide_spacing", b_acc_t[1] - b_acc_t[0], WB + 2);
            check("wide_latency", b_rsp_t[0] - b_acc_t[0], WB + 1);
            check("wide_rsp0", b_rsp_v[0], {4'b1100, {WB{1'b0}}});
            check("wide_rsp1", b_rsp_v[1], {4'b1000, 128'd1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
